stopwatch_mmss_core: RTL and testbench

// - Parametrised mm:ss stopwatch/countdown core. Next generation of the 4-digit BCD stopwatch.
// - Adds an internal tick divider, configurable limits and step, optional wrap-around, a DONE flag and load-from-bus.
// - Sits between debounced panel buttons and four 7-segment digits.

---
 rtl/stopwatch_mmss_core.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_stopwatch_mmss_core.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mmss_core.sv
// mm:ss stopwatch/countdown core: tick divider, BCD mixed-radix counter, limits, step, DONE/ERR, 7-segment output.
// Optional lap-freeze display is built when STOPWATCH_LAP_EN is defined.
//
// state  | meaning
// S_IDLE | paused; START=1 latches direction and runs
// S_RUN  | counting on each divider tick
// S_DONE | terminal value reached with WRAP=0; Q held
// S_ERR  | speed or direction fault; Q held, error code displayed
module stopwatch_mmss_core #(
    parameter int          TICK_DIV    = 50_000_000,
    parameter int          SPEED_SHIFT = 2,
    parameter logic [15:0] UP_LIMIT    = 16'h5959,
    parameter logic [15:0] DOWN_LIMIT  = 16'h0000,
    parameter logic [15:0] STEP        = 16'h0010,
    parameter bit          WRAP        = 1'b0
) (
    input  logic        clk_in,
    input  logic        RESET,
    input  logic        START,
    input  logic        REVERSE,
    input  logic        SPEED_UP,
    input  logic        SPEED_DOWN,
    input  logic        ADD,
    input  logic        SUBTRACT,
    input  logic        LOAD,
    input  logic [15:0] LOAD_VALUE,
`ifdef STOPWATCH_LAP_EN
    input  logic        LAP,
`endif
    output logic [15:0] Q,
    output logic [27:0] D_Q,
    output logic        DONE,
    output logic        ERROR
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

    localparam logic [31:0] P_NORM = 32'(TICK_DIV);
    localparam logic [31:0] P_FAST = 32'(TICK_DIV >> SPEED_SHIFT);
    localparam logic [31:0] P_SLOW = 32'(TICK_DIV << SPEED_SHIFT);

    // Digit radices from sec units upward: 10, 6, 10, 10. Result bit 16 is the final carry.
    function automatic logic [16:0] mmss_add(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  t;
        logic [3:0]  rad;
        logic        c;
        logic [15:0] s;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            rad = (i == 1) ? 4'd6 : 4'd10;
            t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (t >= {1'b0, rad}) begin
                t = t - {1'b0, rad};
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[4*i +: 4] = t[3:0];
        end
        return {c, s};
    endfunction

    function automatic logic [16:0] mmss_sub(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  t;
        logic [3:0]  rad;
        logic        c;
        logic [15:0] s;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            rad = (i == 1) ? 4'd6 : 4'd10;
            t = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, c};
            if (t[4]) begin
                t = t + {1'b0, rad};
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[4*i +: 4] = t[3:0];
        end
        return {c, s};
    endfunction

    function automatic logic lt16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[16];
    endfunction

    function automatic logic mmss_ok(input logic [15:0] v);
        return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) &&
               (v[3:0] <= 4'd9) && !lt16(v, DOWN_LIMIT) && !lt16(UP_LIMIT, v);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    state_t      r_state, w_state_nxt;
    logic [15:0] r_q, w_q_nxt;
    logic        r_dir, w_dir_nxt;
    logic        r_err_rev, w_err_rev_nxt;
    logic [31:0] r_div;
    logic        r_add_d, r_sub_d;
    logic [31:0] r_blink_cnt;
    logic        r_blink_off;
    logic [27:0] r_dq;

    logic        w_spd_err, w_rev_err;
    logic        w_add_e, w_sub_e, w_step_add, w_step_sub, w_step;
    logic        w_load_ok;
    logic [16:0] w_sum, w_dif, w_inc, w_dec;
    logic [15:0] w_q_add, w_q_sub;
    logic [31:0] w_period;
    logic        w_div_hit, w_tick;
    logic [15:0] w_disp_val;
    logic        w_blank;
    logic [27:0] w_dq_nxt;

`ifdef STOPWATCH_LAP_EN
    logic        r_lap_d, r_lap_frz;
    logic [15:0] r_lap_q;
    logic        w_lap_e;
    assign w_lap_e = LAP & ~r_lap_d;
`endif

    assign w_spd_err  = SPEED_UP & SPEED_DOWN;
    assign w_rev_err  = (r_state == S_RUN) && (REVERSE != r_dir);
    assign w_add_e    = ADD & ~r_add_d;
    assign w_sub_e    = SUBTRACT & ~r_sub_d;
    assign w_step_add = w_add_e & ~w_sub_e;
    assign w_step_sub = w_sub_e & ~w_add_e;
    assign w_step     = w_step_add | w_step_sub;
    assign w_load_ok  = LOAD && mmss_ok(LOAD_VALUE);

    assign w_sum   = mmss_add(r_q, STEP);
    assign w_dif   = mmss_sub(r_q, STEP);
    assign w_inc   = mmss_add(r_q, 16'h0001);
    assign w_dec   = mmss_sub(r_q, 16'h0001);
    assign w_q_add = (w_sum[16] || lt16(UP_LIMIT, w_sum[15:0])) ? UP_LIMIT : w_sum[15:0];
    assign w_q_sub = (w_dif[16] || lt16(w_dif[15:0], DOWN_LIMIT)) ? DOWN_LIMIT : w_dif[15:0];

    assign w_period  = SPEED_UP ? P_FAST : (SPEED_DOWN ? P_SLOW : P_NORM);
    assign w_div_hit = (r_div >= (w_period - 32'd1));
    assign w_tick    = (r_state == S_RUN) && START && w_div_hit;

    always_comb begin
        w_state_nxt   = r_state;
        w_q_nxt       = r_q;
        w_dir_nxt     = r_dir;
        w_err_rev_nxt = r_err_rev;
        if (w_spd_err || w_rev_err) begin
            if (r_state != S_ERR) w_err_rev_nxt = w_rev_err;
            w_state_nxt = S_ERR;
        end else if (r_state == S_ERR) begin
            if (!(r_err_rev && (REVERSE != r_dir))) begin
                w_state_nxt   = S_IDLE;
                w_err_rev_nxt = 1'b0;
            end
        end else begin
            if (w_load_ok) begin
                w_q_nxt = LOAD_VALUE;
            end else if (w_step_add) begin
                w_q_nxt = w_q_add;
            end else if (w_step_sub) begin
                w_q_nxt = w_q_sub;
            end else if (w_tick) begin
                if (!r_dir) begin
                    if (r_q == UP_LIMIT || w_inc[16]) begin
                        if (WRAP) w_q_nxt = DOWN_LIMIT;
                        else      w_state_nxt = S_DONE;
                    end else begin
                        w_q_nxt = w_inc[15:0];
                    end
                end else begin
                    if (r_q == DOWN_LIMIT || w_dec[16]) begin
                        if (WRAP) w_q_nxt = UP_LIMIT;
                        else      w_state_nxt = S_DONE;
                    end else begin
                        w_q_nxt = w_dec[15:0];
                    end
                end
            end
            case (r_state)
                S_IDLE: if (START) begin
                    w_state_nxt = S_RUN;
                    w_dir_nxt   = REVERSE;
                end
                S_RUN:  if (!START) w_state_nxt = S_IDLE;
                S_DONE: if (!START || w_load_ok || w_step) w_state_nxt = S_IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_disp_val = r_q;
        w_blank    = 1'b0;
        if (r_state == S_ERR) begin
            if (r_err_rev && !w_spd_err) begin
                w_disp_val = 16'h1111;
            end else begin
                w_disp_val = 16'h5555;
                w_blank    = r_blink_off;
            end
        end
`ifdef STOPWATCH_LAP_EN
        else if (r_lap_frz) begin
            w_disp_val = r_lap_q;
        end
`endif
        w_dq_nxt = w_blank ? 28'd0 : {seg7(w_disp_val[15:12]), seg7(w_disp_val[11:8]),
                                      seg7(w_disp_val[7:4]),   seg7(w_disp_val[3:0])};
    end

    always_ff @(posedge clk_in) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_q         <= 16'h0000;
            r_dir       <= 1'b0;
            r_err_rev   <= 1'b0;
            r_div       <= '0;
            r_add_d     <= 1'b0;
            r_sub_d     <= 1'b0;
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
            r_dq        <= {4{7'h3F}};
        end else begin
            r_state   <= w_state_nxt;
            r_q       <= w_q_nxt;
            r_dir     <= w_dir_nxt;
            r_err_rev <= w_err_rev_nxt;
            r_add_d   <= ADD;
            r_sub_d   <= SUBTRACT;
            r_dq      <= w_dq_nxt;
            // A load or step restarts the period so the next tick is a full interval away.
            if (r_state == S_RUN && w_state_nxt == S_RUN && !(w_load_ok || w_step || w_div_hit))
                r_div <= r_div + 32'd1;
            else
                r_div <= '0;
            if (r_state != S_ERR) begin
                r_blink_cnt <= '0;
                r_blink_off <= 1'b0;
            end else if (r_blink_cnt >= (P_NORM - 32'd1)) begin
                r_blink_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_blink_cnt <= r_blink_cnt + 32'd1;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk_in) begin
        if (RESET) begin
            r_lap_d   <= 1'b0;
            r_lap_frz <= 1'b0;
            r_lap_q   <= 16'h0000;
        end else begin
            r_lap_d <= LAP;
            if (r_state != S_RUN || w_state_nxt != S_RUN) begin
                r_lap_frz <= 1'b0;
            end else if (w_lap_e) begin
                r_lap_frz <= ~r_lap_frz;
                r_lap_q   <= r_q;
            end
        end
    end
`endif

    assign Q     = r_q;
    assign D_Q   = r_dq;
    assign DONE  = (r_state == S_DONE);
    assign ERROR = (r_state == S_ERR);

endmodule

// File: tb/tb_stopwatch_mmss_core.sv
// Bench for stopwatch_mmss_core: a WRAP=0 instance checked by a Q-change scoreboard, plus a WRAP=1 twin.
module tb_stopwatch_mmss_core;

    logic        clk;
    logic        rst, start, rev, spd_up, spd_dn, add, sub, load;
    logic [15:0] load_val;
    logic [15:0] q, q_w;
    logic [27:0] dq, dq_w;
    logic        done, err, done_w, err_w;
`ifdef STOPWATCH_LAP_EN
    logic        lap;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          mon_en = 0;
    logic [15:0] prev_q;
    logic [15:0] exp_q[$];
    int          chg_cyc[$];

    stopwatch_mmss_core #(.TICK_DIV(4), .SPEED_SHIFT(1), .WRAP(1'b0)) u_dut (
        .clk_in(clk), .RESET(rst), .START(start), .REVERSE(rev), .SPEED_UP(spd_up),
        .SPEED_DOWN(spd_dn), .ADD(add), .SUBTRACT(sub), .LOAD(load), .LOAD_VALUE(load_val),
`ifdef STOPWATCH_LAP_EN
        .LAP(lap),
`endif
        .Q(q), .D_Q(dq), .DONE(done), .ERROR(err));

    stopwatch_mmss_core #(.TICK_DIV(4), .SPEED_SHIFT(1), .WRAP(1'b1)) u_dut_w (
        .clk_in(clk), .RESET(rst), .START(start), .REVERSE(rev), .SPEED_UP(spd_up),
        .SPEED_DOWN(spd_dn), .ADD(add), .SUBTRACT(sub), .LOAD(load), .LOAD_VALUE(load_val),
`ifdef STOPWATCH_LAP_EN
        .LAP(lap),
`endif
        .Q(q_w), .D_Q(dq_w), .DONE(done_w), .ERROR(err_w));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] seg1(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [27:0] seg4(input logic [15:0] v);
        return {seg1(v[15:12]), seg1(v[11:8]), seg1(v[7:4]), seg1(v[3:0])};
    endfunction

    // Scoreboard: every change of Q must match the next expected value.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en && (q !== prev_q)) begin
                chg_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL q_unexpected: Q became %h, no change expected", q);
                end else begin
                    e = exp_q.pop_front();
                    if (q !== e) begin
                        errors++;
                        $display("FAIL q_sequence: Q=%h expected %h", q, e);
                    end
                end
            end
            prev_q = q;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        start = 0; rev = 0; spd_up = 0; spd_dn = 0; add = 0; sub = 0; load = 0; load_val = 16'h0;
`ifdef STOPWATCH_LAP_EN
        lap = 0;
`endif
    endtask

    task automatic reset_dut();
        mon_en = 0;
        idle_inputs();
        rst = 1;
        cycles(2);
        rst = 0;
        cycles(1);
        exp_q.delete();
        chg_cyc.delete();
        mon_en = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        checks++; if (dq !== seg4(16'h0000)) begin errors++; $display("FAIL reset_dq: D_Q=%h expected %h", dq, seg4(16'h0000)); end
        checks++; if (q !== 16'h0000) begin errors++; $display("FAIL reset_q: Q=%h expected 0000", q); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: DONE=%b ERROR=%b expected 0 0", done, err); end
        cycles(1);
        rst = 0;
        cycles(1);
        mon_en = 1;
    endtask

    task automatic test_count();
        reset_dut();
        for (int i = 1; i <= 9; i++) exp_q.push_back(16'(i));
        exp_q.push_back(16'h0010);
        start = 1;
        drain(80);
        start = 0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL count_timeout: %0d values pending, expected 0", exp_q.size()); end
        checks++; if (q !== 16'h0010) begin errors++; $display("FAIL count_q: Q=%h expected 0010", q); end
        checks++; if (chg_cyc.size() != 10) begin errors++; $display("FAIL count_changes: %0d changes expected 10", chg_cyc.size()); end
        for (int i = 1; i < chg_cyc.size(); i++) begin
            checks++;
            if (chg_cyc[i] - chg_cyc[i-1] != 4) begin errors++; $display("FAIL count_period: gap %0d expected 4", chg_cyc[i] - chg_cyc[i-1]); end
        end
        cycles(2);
        checks++; if (dq !== seg4(16'h0010)) begin errors++; $display("FAIL count_dq: D_Q=%h expected %h", dq, seg4(16'h0010)); end
    endtask

    task automatic test_load();
        reset_dut();
        exp_q.push_back(16'h0059);
        load = 1; load_val = 16'h0059;
        cycles(1);
        load = 0;
        exp_q.push_back(16'h0100);
        start = 1;
        drain(20);
        start = 0;
        checks++; if (q !== 16'h0100) begin errors++; $display("FAIL load_tick: Q=%h expected 0100", q); end
        load = 1; load_val = 16'h0075;
        cycles(1);
        load = 0;
        cycles(3);
        checks++; if (q !== 16'h0100) begin errors++; $display("FAIL load_bad_sec: Q=%h expected 0100", q); end
        load = 1; load_val = 16'h6000;
        cycles(1);
        load = 0;
        cycles(3);
        checks++; if (q !== 16'h0100) begin errors++; $display("FAIL load_over_limit: Q=%h expected 0100", q); end
        exp_q.push_back(16'h0200);
        load = 1; load_val = 16'h0200; add = 1;
        cycles(1);
        load = 0; add = 0;
        cycles(3);
        checks++; if (q !== 16'h0200 || exp_q.size() != 0) begin errors++; $display("FAIL load_over_add: Q=%h expected 0200", q); end
    endtask

    task automatic test_wrap_done();
        reset_dut();
        exp_q.push_back(16'h5958);
        load = 1; load_val = 16'h5958;
        cycles(1);
        load = 0;
        exp_q.push_back(16'h5959);
        start = 1;
        drain(20);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout: %0d pending expected 0", exp_q.size()); end
        cycles(6);
        checks++; if (done !== 1'b1 || q !== 16'h5959) begin errors++; $display("FAIL done_enter: DONE=%b Q=%h expected 1 5959", done, q); end
        checks++; if (q_w !== 16'h0000 || done_w !== 1'b0 || err_w !== 1'b0) begin errors++; $display("FAIL wrap_q: Q=%h DONE=%b ERROR=%b expected 0000 0 0", q_w, done_w, err_w); end
        checks++; if (dq_w !== seg4(16'h0000)) begin errors++; $display("FAIL wrap_dq: D_Q=%h expected %h", dq_w, seg4(16'h0000)); end
        cycles(8);
        checks++; if (done !== 1'b1 || q !== 16'h5959) begin errors++; $display("FAIL done_hold: DONE=%b Q=%h expected 1 5959", done, q); end
        start = 0;
        cycles(2);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_exit: DONE=%b expected 0", done); end
    endtask

    task automatic test_step();
        reset_dut();
        exp_q.push_back(16'h5955);
        load = 1; load_val = 16'h5955;
        cycles(1);
        load = 0;
        exp_q.push_back(16'h5959);
        add = 1; cycles(1); add = 0; cycles(1);
        checks++; if (q !== 16'h5959) begin errors++; $display("FAIL step_sat_up: Q=%h expected 5959", q); end
        rev = 1;
        exp_q.push_back(16'h0005);
        load = 1; load_val = 16'h0005;
        cycles(1);
        load = 0;
        exp_q.push_back(16'h0015);
        add = 1; cycles(1); add = 0; cycles(1);
        exp_q.push_back(16'h0005);
        sub = 1; cycles(1); sub = 0; cycles(1);
        exp_q.push_back(16'h0000);
        sub = 1; cycles(1); sub = 0; cycles(1);
        checks++; if (q !== 16'h0000 || exp_q.size() != 0) begin errors++; $display("FAIL step_sat_down: Q=%h expected 0000", q); end
        start = 1;
        for (int k = 0; k < 12 && done !== 1'b1; k++) cycles(1);
        checks++; if (done !== 1'b1 || q !== 16'h0000) begin errors++; $display("FAIL down_done: DONE=%b Q=%h expected 1 0000", done, q); end
        add = 1; sub = 1;
        cycles(1);
        add = 0; sub = 0;
        cycles(3);
        checks++; if (done !== 1'b1 || q !== 16'h0000) begin errors++; $display("FAIL step_both: DONE=%b Q=%h expected 1 0000", done, q); end
        exp_q.push_back(16'h0010);
        exp_q.push_back(16'h0009);
        add = 1;
        cycles(1);
        add = 0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL step_done_exit: DONE=%b expected 0", done); end
        drain(20);
        start = 0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL step_rerun: %0d pending expected 0", exp_q.size()); end
        cycles(2);
    endtask

    task automatic test_speed();
        reset_dut();
        spd_up = 1;
        for (int i = 1; i <= 3; i++) exp_q.push_back(16'(i));
        start = 1;
        drain(30);
        start = 0;
        checks++; if (chg_cyc.size() != 3) begin errors++; $display("FAIL fast_changes: %0d expected 3", chg_cyc.size()); end
        for (int i = 1; i < chg_cyc.size(); i++) begin
            checks++;
            if (chg_cyc[i] - chg_cyc[i-1] != 2) begin errors++; $display("FAIL fast_period: gap %0d expected 2", chg_cyc[i] - chg_cyc[i-1]); end
        end
        spd_up = 0; spd_dn = 1;
        cycles(2);
        chg_cyc.delete();
        for (int i = 4; i <= 6; i++) exp_q.push_back(16'(i));
        start = 1;
        drain(60);
        start = 0;
        checks++; if (chg_cyc.size() != 3) begin errors++; $display("FAIL slow_changes: %0d expected 3", chg_cyc.size()); end
        for (int i = 1; i < chg_cyc.size(); i++) begin
            checks++;
            if (chg_cyc[i] - chg_cyc[i-1] != 8) begin errors++; $display("FAIL slow_period: gap %0d expected 8", chg_cyc[i] - chg_cyc[i-1]); end
        end
        spd_dn = 0;
        cycles(2);
    endtask

    task automatic test_errors();
        logic [27:0] want;
        reset_dut();
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        start = 1;
        drain(30);
        spd_up = 1; spd_dn = 1;
        cycles(1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL spd_err_enter: ERROR=%b expected 1", err); end
        for (int k = 1; k <= 12; k++) begin
            cycles(1);
            want = (((k - 1) / 4) % 2 == 0) ? seg4(16'h5555) : 28'd0;
            checks++;
            if (dq !== want) begin errors++; $display("FAIL spd_blink k=%0d: D_Q=%h expected %h", k, dq, want); end
        end
        checks++; if (q !== 16'h0002) begin errors++; $display("FAIL spd_q_frozen: Q=%h expected 0002", q); end
        spd_up = 0; spd_dn = 0; start = 0;
        cycles(2);
        checks++; if (err !== 1'b0 || done !== 1'b0 || dq !== seg4(16'h0002)) begin errors++; $display("FAIL spd_exit: ERROR=%b D_Q=%h expected 0 %h", err, dq, seg4(16'h0002)); end
        start = 1;
        cycles(1);
        rev = 1;
        cycles(2);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rev_err_enter: ERROR=%b expected 1", err); end
        cycles(4);
        checks++; if (dq !== seg4(16'h1111) || q !== 16'h0002) begin errors++; $display("FAIL rev_err_code: D_Q=%h Q=%h expected %h 0002", dq, q, seg4(16'h1111)); end
        start = 0; rev = 0;
        cycles(2);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rev_err_exit: ERROR=%b expected 0", err); end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        reset_dut();
        for (int i = 1; i <= 3; i++) exp_q.push_back(16'(i));
        start = 1;
        drain(30);
        lap = 1;
        cycles(1);
        lap = 0;
        for (int i = 4; i <= 6; i++) exp_q.push_back(16'(i));
        drain(30);
        checks++; if (dq !== seg4(16'h0003) || q !== 16'h0006) begin errors++; $display("FAIL lap_freeze: D_Q=%h Q=%h expected %h 0006", dq, q, seg4(16'h0003)); end
        lap = 1;
        cycles(1);
        lap = 0;
        cycles(1);
        checks++; if (dq !== seg4(16'h0006)) begin errors++; $display("FAIL lap_release: D_Q=%h expected %h", dq, seg4(16'h0006)); end
        start = 0;
        cycles(2);
    endtask
`endif

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_count();
        test_load();
        test_wrap_done();
        test_step();
        test_speed();
        test_errors();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: %0d pending expected 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
